// File: rtl/lab3_sequence_generator.sv
// Serial pattern transmitter: loads a programmable-length pattern on start, shifts it out MSB-first.
// Optional SEQGEN_REPEAT_EN adds the rpt input for gapless pattern repetition.
module lab3_sequence_generator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    length,
`ifdef SEQGEN_REPEAT_EN
  input  logic             rpt,
`endif
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    len_clamped;

  assign len_clamped = (length > LW'(WIDTH)) ? LW'(WIDTH) : length;

`ifdef SEQGEN_REPEAT_EN
  logic [WIDTH-1:0] pat_copy_q, pat_copy_d;
  logic [LW-1:0]    len_copy_q, len_copy_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SEQGEN_REPEAT_EN
    pat_copy_d = pat_copy_q;
    len_copy_d = len_copy_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && (length != '0)) begin
          shreg_d = pattern;
          cnt_d   = len_clamped;
          state_d = StSend;
`ifdef SEQGEN_REPEAT_EN
          pat_copy_d = pattern;
          len_copy_d = len_clamped;
`endif
        end
      end
      StSend: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
`ifdef SEQGEN_REPEAT_EN
          // Reload from the captured copy so the next pattern follows with no gap
          if (rpt) begin
            shreg_d = pat_copy_q;
            cnt_d   = len_copy_q;
          end else begin
            state_d = StDone;
          end
`else
          state_d = StDone;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef SEQGEN_REPEAT_EN
      pat_copy_q <= '0;
      len_copy_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef SEQGEN_REPEAT_EN
      pat_copy_q <= pat_copy_d;
      len_copy_q <= len_copy_d;
`endif
    end
  end

  // Outputs decode registered state only
  assign x     = (state_q == StSend) & shreg_q[WIDTH-1];
  assign valid = (state_q == StSend);
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);

endmodule

// File: tb/tb_lab3_sequence_generator.sv
// Self-checking bench for lab3_sequence_generator: vector table, corner sequences, random vs. model.
module tb_lab3_sequence_generator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LW    = $clog2(WIDTH + 1);

  localparam logic [3:0] IdleO = 4'b0000;  // {x, valid, busy, done}
  localparam logic [3:0] DoneO = 4'b0011;

  typedef struct {
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    length;
    int               exp_len;
    logic [WIDTH-1:0] exp_bits;  // expected stream, MSB-aligned
  } vec_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    length;
  logic             x, valid, busy, done;
`ifdef SEQGEN_REPEAT_EN
  logic             rpt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vec_t       vecs[7];
  logic [3:0] q[$];

  always #5 clock = ~clock;

  lab3_sequence_generator #(
    .WIDTH(WIDTH),
    .LW   (LW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .pattern(pattern),
    .length (length),
`ifdef SEQGEN_REPEAT_EN
    .rpt    (rpt),
`endif
    .x      (x),
    .valid  (valid),
    .busy   (busy),
    .done   (done)
  );

  task automatic expect_out(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {x, valid, busy, done};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: x/valid/busy/done got %b required %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] bit_o(input logic b);
    return {b, 3'b110};
  endfunction

  initial begin
    vecs[0] = '{8'b0100_0000, 4'd3,  3, 8'b0100_0000};
    vecs[1] = '{8'hA5,        4'd12, 8, 8'hA5};
    vecs[2] = '{8'hFF,        4'd1,  1, 8'b1000_0000};
    vecs[3] = '{8'h81,        4'd8,  8, 8'h81};
    vecs[4] = '{8'h3C,        4'd5,  5, 8'b0011_1000};
    vecs[5] = '{8'hFF,        4'd0,  0, 8'h00};
    vecs[6] = '{8'h5A,        4'd9,  8, 8'h5A};

    reset   = 1'b0;
    start   = 1'b0;
    pattern = '0;
    length  = '0;
`ifdef SEQGEN_REPEAT_EN
    rpt     = 1'b0;
`endif
    repeat (3) @(negedge clock);
    expect_out("reset state", IdleO);
    reset = 1'b1;
    @(negedge clock);
    expect_out("idle after reset", IdleO);

    // Table: each vector starts in the idle cycle left by the previous one
    for (int v = 0; v < 7; v++) begin
      pattern = vecs[v].pattern;
      length  = vecs[v].length;
      start   = 1'b1;
      @(negedge clock);
      start   = 1'b0;
      pattern = WIDTH'($urandom);
      length  = LW'($urandom);
      for (int i = 0; i < vecs[v].exp_len; i++) begin
        expect_out($sformatf("vec%0d bit%0d", v, i), bit_o(vecs[v].exp_bits[WIDTH-1-i]));
        @(negedge clock);
      end
      if (vecs[v].exp_len > 0) begin
        expect_out($sformatf("vec%0d done", v), DoneO);
        @(negedge clock);
      end else begin
        expect_out($sformatf("vec%0d len0 ignored", v), IdleO);
        @(negedge clock);
      end
      expect_out($sformatf("vec%0d idle", v), IdleO);
    end

    // start re-pulsed during SEND must not disturb the running pattern
    pattern = 8'hC3;
    length  = 4'd8;
    start   = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ref_pat;
      ref_pat = 8'hC3;
      expect_out($sformatf("repulse bit%0d", i), bit_o(ref_pat[WIDTH-1-i]));
      start   = 1'b1;
      pattern = 8'h0F;
      length  = 4'd4;
      @(negedge clock);
    end
    start = 1'b0;
    expect_out("repulse done", DoneO);
    @(negedge clock);
    expect_out("repulse idle1", IdleO);
    @(negedge clock);
    expect_out("repulse idle2", IdleO);

    // Reset mid-transmission abandons the pattern with no done
    pattern = 8'hFF;
    length  = 4'd8;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    expect_out("abort bit0", bit_o(1'b1));
    @(negedge clock);
    expect_out("abort bit1", bit_o(1'b1));
    reset = 1'b0;
    @(negedge clock);
    expect_out("abort reset", IdleO);
    reset = 1'b1;
    @(negedge clock);
    expect_out("abort no done", IdleO);
    pattern = 8'h96;
    length  = 4'd8;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ref_pat;
      ref_pat = 8'h96;
      expect_out($sformatf("after abort bit%0d", i), bit_o(ref_pat[WIDTH-1-i]));
      @(negedge clock);
    end
    expect_out("after abort done", DoneO);
    @(negedge clock);
    expect_out("after abort idle", IdleO);

`ifdef SEQGEN_REPEAT_EN
    pattern = 8'hC0;
    length  = 4'd2;
    rpt     = 1'b1;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expect_out($sformatf("repeat cyc%0d", i), bit_o(1'b1));
      if (i == 6) rpt = 1'b0;
      @(negedge clock);
    end
    expect_out("repeat last bit", bit_o(1'b1));
    @(negedge clock);
    expect_out("repeat done", DoneO);
    @(negedge clock);
    expect_out("repeat idle", IdleO);
`endif

    // Random traffic against a cycle-stream model of expected outputs
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [3:0] e;
      bit         idle_now;
      int         l;
      if (q.size() == 0) begin
        e        = IdleO;
        idle_now = 1'b1;
      end else begin
        e        = q.pop_front();
        idle_now = 1'b0;
      end
      expect_out($sformatf("rand cyc%0d", cyc), e);
      start   = ($urandom_range(3) == 0);
      pattern = WIDTH'($urandom);
      length  = LW'($urandom_range(WIDTH + 3, 0));
      reset   = ($urandom_range(49) != 0);
      if (!reset) begin
        q.delete();
      end else if (idle_now && start && (length != 0)) begin
        l = (int'(length) > int'(WIDTH)) ? int'(WIDTH) : int'(length);
        for (int i = 0; i < l; i++) q.push_back(bit_o(pattern[WIDTH-1-i]));
        q.push_back(DoneO);
      end
      @(negedge clock);
    end
    reset = 1'b1;
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
